// File: rtl/capture_seq_ctrl.sv
// Debounced two-key capture sequencer: captures sw into a 4-entry byte bank and selects the displayed entry.
// Optional auto-scroll of the displayed entry is enabled by defining CAPTURE_AUTOSCROLL_EN.
module capture_seq_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned SCROLL_CYCLES   = 50000000
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       key_cap_n,
   input  logic       key_view_n,
   input  logic [7:0] sw,
   output logic       cap_strobe,
   output logic [1:0] wr_idx,
   output logic [2:0] count,
   output logic       full,
   output logic [1:0] disp_idx,
   output logic [7:0] disp_data
);

   localparam int unsigned CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StArmed = 2'd1;
   localparam logic [1:0] StFire  = 2'd2;
   localparam logic [1:0] StHold  = 2'd3;

   logic [1:0]          sync1_q, sync2_q;
   logic [1:0]          state_q [2];
   logic [1:0]          state_d [2];
   logic [CntWidth-1:0] cnt_q [2];
   logic [CntWidth-1:0] cnt_d [2];
   logic [7:0]          bank_q [4];
   logic [1:0]          wrIdx_q, dispIdx_q;
   logic [2:0]          count_q;
   logic                capEvt, viewEvt;
   logic [1:0]          viewNext;

   // Sync flops idle high so a key held through reset still needs a full debounce.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
      end else begin
         sync1_q <= {key_view_n, key_cap_n};
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         state_d[k] = state_q[k];
         cnt_d[k]   = cnt_q[k];
         case (state_q[k])
            StIdle: begin
               cnt_d[k] = '0;
               if (!sync2_q[k]) state_d[k] = StArmed;
            end
            StArmed: begin
               if (sync2_q[k]) begin
                  state_d[k] = StIdle;
                  cnt_d[k]   = '0;
               end else if (cnt_q[k] == CntLast) begin
                  state_d[k] = StFire;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
            StFire: begin
               state_d[k] = StHold;
               cnt_d[k]   = '0;
            end
            default: begin
               if (!sync2_q[k]) begin
                  cnt_d[k] = '0;
               end else if (cnt_q[k] == CntLast) begin
                  state_d[k] = StIdle;
                  cnt_d[k]   = '0;
               end else begin
                  cnt_d[k] = cnt_q[k] + 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= StIdle;
            cnt_q[k]   <= '0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            state_q[k] <= state_d[k];
            cnt_q[k]   <= cnt_d[k];
         end
      end
   end

   assign capEvt  = (state_q[0] == StFire);
   assign viewEvt = (state_q[1] == StFire);

   // Advance modulo the number of valid entries; dispIdx_q is always below count_q when count_q is nonzero.
   assign viewNext = (({1'b0, dispIdx_q} + 3'd1) >= count_q) ? 2'd0 : dispIdx_q + 2'd1;

`ifdef CAPTURE_AUTOSCROLL_EN
   localparam int unsigned ScrollWidth = $clog2(SCROLL_CYCLES + 1);
   localparam logic [ScrollWidth-1:0] ScrollLast = ScrollWidth'(SCROLL_CYCLES - 1);

   logic [ScrollWidth-1:0] scroll_q;
   logic                   scrollHit;

   assign scrollHit = (scroll_q == ScrollLast);

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         scroll_q <= '0;
      end else if (capEvt || viewEvt || scrollHit) begin
         scroll_q <= '0;
      end else begin
         scroll_q <= scroll_q + 1'b1;
      end
   end
`else
   logic unusedScrollCycles;
   logic scrollHit;

   assign unusedScrollCycles = ^SCROLL_CYCLES;
   assign scrollHit          = 1'b0;
`endif

   // Capture beats view beats scroll; a full bank overwrites the oldest slot at wrIdx_q.
   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 4; i++) bank_q[i] <= 8'h00;
         wrIdx_q   <= 2'd0;
         dispIdx_q <= 2'd0;
         count_q   <= 3'd0;
      end else if (capEvt) begin
         bank_q[wrIdx_q] <= sw;
         dispIdx_q       <= wrIdx_q;
         wrIdx_q         <= wrIdx_q + 2'd1;
         if (count_q != 3'd4) count_q <= count_q + 3'd1;
      end else if (viewEvt) begin
         if (count_q != 3'd0) dispIdx_q <= viewNext;
      end else if (scrollHit && (count_q >= 3'd2)) begin
         dispIdx_q <= viewNext;
      end
   end

   assign cap_strobe = capEvt;
   assign wr_idx     = wrIdx_q;
   assign count      = count_q;
   assign full       = (count_q == 3'd4);
   assign disp_idx   = dispIdx_q;
   assign disp_data  = bank_q[dispIdx_q];

endmodule

// File: doc/capture_seq_ctrl.md
# capture_seq_ctrl

Controller for the DE1 switch-capture datapath. It debounces two push-buttons and sequences 8-bit captures of `sw` into a 4-entry byte bank. It selects which captured entry drives the downstream hex-decoder display path. It sits between the raw KEY inputs, the SW bus and the `Decoder_HEX`-style display decoders.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: number of consecutive stable cycles needed to qualify a press or release (1 ms at 50 MHz).
- `SCROLL_CYCLES`, default 50000000: auto-scroll period in cycles; used only with `CAPTURE_AUTOSCROLL_EN`.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-low reset.
- `key_cap_n` input 1: raw capture button, active-low, asynchronous.
- `key_view_n` input 1: raw view button, active-low, asynchronous.
- `sw` input 8: switch value to capture; quasi-static.
- `cap_strobe` output 1: one-cycle pulse in the cycle a capture is written.
- `wr_idx` output 2: slot that the next capture writes.
- `count` output 3: number of valid entries, 0..4.
- `full` output 1: high when `count == 4`.
- `disp_idx` output 2: slot currently displayed.
- `disp_data` output 8: `bank[disp_idx]`, combinational from registers. `disp_data[7:4]` feeds the high digit; `[3:0]` feeds the low digit.

## Operation
- Each key input passes through a 2-FF synchronizer, then a per-key debounce FSM with states IDLE, ARMED, FIRE and HOLD.
  - IDLE: go to ARMED when the synced key is low; the counter is cleared.
  - ARMED: the counter increments while the key is low. If the key goes high, return to IDLE. When the counter reaches `DEBOUNCE_CYCLES-1`, go to FIRE.
  - FIRE: lasts exactly one cycle and produces the qualified press event. Next state is HOLD; the counter is cleared.
  - HOLD: the counter increments while the key is high and clears when the key is low. When it reaches `DEBOUNCE_CYCLES-1`, go to IDLE.
  - A held key produces exactly one event.
- Capture event (capture FSM in FIRE):
  - `bank[wr_idx] <= sw`, with `sw` sampled in that cycle.
  - `cap_strobe = 1`.
  - `disp_idx <= wr_idx`.
  - `wr_idx <= wr_idx + 1` (mod 4).
  - `count <= min(count + 1, 4)`.
- Overwrite policy when full: the capture overwrites the oldest slot, which is the slot at `wr_idx`. `count` stays at 4.
- View event (view FSM in FIRE):
  - If `count == 0`, `disp_idx` is unchanged.
  - Otherwise `disp_idx <= (disp_idx + 1) mod count`.
- Simultaneous capture and view events in the same cycle: the capture wins and the view event is discarded. The view FSM still proceeds to HOLD.
- Reset clears every output to 0:
  - `bank[0..3] = 8'h00`.
  - `cap_strobe`, `wr_idx`, `count`, `full` and `disp_idx` are 0.
  - Both FSMs go to IDLE with counters at 0.
  - `disp_data = 8'h00`.
- Reset asserted mid-debounce or mid-hold aborts the sequence with no event. After release, a key already held low must still complete a full ARMED count before it fires.

## Timing
- Capture latency: if `key_cap_n` falls before clock edge 0 and stays low, `cap_strobe` is high in cycle `DEBOUNCE_CYCLES + 3`. This is 2 synchronizer cycles, `DEBOUNCE_CYCLES` ARMED cycles and 1 FIRE cycle.
- Register updates take effect on the FIRE cycle's closing edge:
  - `bank`, `wr_idx`, `count`, `full` and `disp_idx` show their new values in the cycle after `cap_strobe`.
  - `disp_data` follows in the same cycle.
- Glitches shorter than `DEBOUNCE_CYCLES` cycles in either direction produce no event.
- Minimum spacing between two events on one key is `2*DEBOUNCE_CYCLES + 2` cycles.
- `cap_strobe` is never high for two consecutive cycles.

## Configuration
- `CAPTURE_AUTOSCROLL_EN` defined:
  - A free-running counter advances `disp_idx` by the view rule every `SCROLL_CYCLES` cycles while `count >= 2`.
  - The counter restarts at 0 on any capture or view event.
  - Priority order: capture, then view, then scroll.
- `CAPTURE_AUTOSCROLL_EN` undefined: no scroll counter exists, `SCROLL_CYCLES` is ignored, and `disp_idx` changes only on capture or view events.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`.
- Reset, then press `key_cap_n` with `sw = 8'hA5` held for 20 cycles -> a single `cap_strobe` in cycle 7; `bank[0] = A5`, `wr_idx = 1`, `count = 1`, `disp_idx = 0`, `disp_data = A5`.
- Five captures with `sw` = 11, 22, 33, 44, 55 -> `full = 1` after the 4th; the 5th overwrites slot 0 (`bank = {44,33,22,55}`), `count = 4`, `disp_idx = 0`, `wr_idx = 1`.
- 3-cycle low glitch on `key_cap_n`, plus bouncy release (high 2, low 1, high) after a valid press -> exactly one `cap_strobe` in total.
- `count = 3`, `disp_idx = 2`, one view press -> `disp_idx = 0`; view press with `count = 0` -> `disp_idx` stays 0.
- Both keys fall in the same cycle with `sw = 8'h3C` -> capture into slot `wr_idx`, `disp_idx = ` the written slot, and no extra view advance.
- `Reset` pulsed low during ARMED with a key held low -> no `cap_strobe`; all outputs 0; a capture fires 7 cycles after `Reset` is released.
